width_alloc_ctrl: RTL
=====================

# width_alloc_ctrl

Allocation controller that sits in front of the occupied-width RAM and sequences every access to it. It accepts one placement request at a time, carrying an item width and three ranked candidate IDs. It reads the three occupied widths, picks the highest-priority candidate with enough remaining capacity, and commits the width through a single write pulse. It returns the chosen ID, or a failure code, over a valid/ready response handshake, and keeps saturating allocation and failure counters.

## Interface
- CAPACITY, 128: maximum occupied width per ID; a candidate fits if occupied + width <= CAPACITY
- BLOCKED_ID, 13: ID that is never selected; it holds 255 in the RAM
- MIN_W, 4 / MAX_W, 16: legal request width range, inclusive
- enclk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_width  in  5  item width
- req_id1, req_id2, req_id3  in  4  candidate IDs, id1 is the highest priority
- strike  in  1  sampled in EVAL; when high, the request is refused with no write
- resp_valid  out  1  response valid; held until accepted
- resp_ready  in  1  response accepted
- resp_id  out  4  selected ID (0 on failure)
- resp_code  out  2  0 = OK, 1 = NO_FIT, 2 = BAD_WIDTH, 3 = STRIKE
- ram_id1, ram_id2, ram_id3  out  4  RAM read addresses
- ram_width1, ram_width2, ram_width3  in  8  RAM read data (registered inside the RAM)
- ram_we  out  1  RAM write strobe; the RAM writes on the rising edge
- ram_write_id  out  4  RAM write address
- ram_write_width  out  5  RAM write increment
- ram_strike  out  1  RAM write inhibit; this block always drives it to 0 and suppresses writes itself
- alloc_count, fail_count  out  16  saturating event counters

## Operation
- States: IDLE, RD, WAIT, EVAL, WR, WRX, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, latch width and IDs.
  - If the width is outside MIN_W..MAX_W: go to RESP with BAD_WIDTH.
  - Otherwise go to RD.
- **RD, WAIT**
  - Drive ram_id1..3 from the latched IDs; hold them stable from RD through WRX.
  - WAIT covers the RAM's registered read.
- **EVAL**
  - Sample ram_width1..3.
  - If strike=1: result is STRIKE.
  - Otherwise scan id1, id2, id3 in order and select the first candidate that satisfies all of:
    - ID != BLOCKED_ID;
    - ID <= 13;
    - 9-bit sum {1'b0,width_n} + width <= CAPACITY.
  - Duplicate IDs are allowed; the first match wins.
  - If a candidate is selected: go to WR. If none: NO_FIT, go to RESP.
- **WR**: ram_we=1, ram_write_id=selected ID, ram_write_width=latched width.
- **WRX**: ram_we=0, with address and data held. This gives the write a clean falling edge. Then go to RESP.
- **RESP**
  - resp_valid=1; resp_id and resp_code are stable.
  - On resp_ready, return to IDLE.
  - The counter update happens on that handshake cycle: alloc_count+1 if the code is OK, else fail_count+1. Both counters saturate at 16'hFFFF.
- Only one request is in flight at a time; there is no queueing.
- **Reset values**: state IDLE, req_ready=1, resp_valid=0, resp_id=0, resp_code=0, ram_we=0, ram_id*=0, ram_write_id=0, ram_write_width=0, ram_strike=0, counters=0.
- **Reset mid-operation**:
  - The in-flight request is dropped and no response is issued.
  - If reset hits in WR, ram_we drops to 0 asynchronously. Whether the RAM write lands is then irrelevant, because the RAM is reset by the same rst.

## Timing
- Cycle 0: accept (req_valid & req_ready at the clock edge).
- Success path:
  - Cycle 1: RD. Cycle 2: WAIT. Cycle 3: EVAL.
  - Cycle 4: WR, ram_we high. Cycle 5: WRX.
  - Cycle 6: resp_valid.
- NO_FIT or STRIKE: resp_valid at cycle 4; ram_we never asserted.
- BAD_WIDTH: resp_valid at cycle 1; no RAM activity.
- ram_we is high for exactly one enclk cycle per successful request and never otherwise.
- resp_valid held for N stall cycles: outputs stay constant and req_ready stays 0.
- Earliest next acceptance: the cycle after the RESP handshake.
- strike is sampled only in EVAL; toggling it in other states has no effect.

## Test plan
- Reset, then width=8, ids (2,3,4), RAM all 0, strike=0:
  - cycle 4: ram_we pulse with write_id=2, write_width=8;
  - cycle 6: resp_id=2, code=OK;
  - afterwards alloc_count=1.
- Preload ID 2 to 120, width=9, ids (2,5,6):
  - 129 > 128, so ID 2 is skipped;
  - write goes to ID 5; resp_id=5.
- Boundary: ID 2 at 112 with width=16 (sum 128) gives OK on ID 2. ID 2 at 113 with the same request falls through to id2.
- ids (13,13,13), width=4: NO_FIT at cycle 4, no ram_we, fail_count=1. Width=3 and width=17 each give BAD_WIDTH at cycle 1 with no RAM access.
- strike=1 during EVAL with a fitting candidate: STRIKE code, no ram_we. Then hold resp_ready=0 for 5 cycles: resp stays stable and req_ready=0.
- Assert rst during WR: ram_we=0 and resp_valid=0 immediately, counters return to 0, and a new request is accepted in the cycle after rst deasserts.

Source files
------------

// File: rtl/width_alloc_if.sv
// width_alloc_if: request/response handshake and occupied-width RAM port bundle for width_alloc_ctrl
interface width_alloc_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_width;
  logic [3:0]  req_id1, req_id2, req_id3;
  logic        strike;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_id;
  logic [1:0]  resp_code;
  logic [3:0]  ram_id1, ram_id2, ram_id3;
  logic [7:0]  ram_width1, ram_width2, ram_width3;
  logic        ram_we;
  logic [3:0]  ram_write_id;
  logic [4:0]  ram_write_width;
  logic        ram_strike;
  logic [15:0] alloc_count, fail_count;
  modport slave (
    input  req_valid, req_width, req_id1, req_id2, req_id3, strike, resp_ready,
           ram_width1, ram_width2, ram_width3,
    output req_ready, resp_valid, resp_id, resp_code, ram_id1, ram_id2, ram_id3,
           ram_we, ram_write_id, ram_write_width, ram_strike, alloc_count, fail_count
  );
  modport master (
    output req_valid, req_width, req_id1, req_id2, req_id3, strike, resp_ready,
           ram_width1, ram_width2, ram_width3,
    input  req_ready, resp_valid, resp_id, resp_code, ram_id1, ram_id2, ram_id3,
           ram_we, ram_write_id, ram_write_width, ram_strike, alloc_count, fail_count
  );
endinterface

// File: rtl/width_alloc_ctrl.sv
// width_alloc_ctrl: reads three candidate occupancies, commits the first fit with one write pulse, reports via handshake
module width_alloc_ctrl #(
  parameter logic [8:0] CAPACITY   = 9'd128,
  parameter logic [3:0] BLOCKED_ID = 4'd13,
  parameter logic [4:0] MIN_W      = 5'd4,
  parameter logic [4:0] MAX_W      = 5'd16
) (
  input logic enclk,
  input logic rst,
  width_alloc_if.slave io
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, EVAL, WR, WRX, RESP} state_e;
  state_e      state_q, state_d;
  logic [4:0]  width_q, width_d;
  logic [3:0]  id1_q, id1_d, id2_q, id2_d, id3_q, id3_d, sel_q, sel_d;
  logic [1:0]  code_q, code_d;
  logic [15:0] alloc_q, alloc_d, fail_q, fail_d;
  logic        fit1, fit2, fit3, any_fit, ram_busy, wr_phase;
  // 9-bit sum so a nearly full ID (e.g. 250) cannot wrap into a false fit
  function automatic logic fits(input logic [3:0] id, input logic [7:0] occ, input logic [4:0] w);
    return id != BLOCKED_ID && id <= 4'd13 && ({1'b0, occ} + {4'b0, w}) <= CAPACITY;
  endfunction
  assign fit1    = fits(id1_q, io.ram_width1, width_q);
  assign fit2    = fits(id2_q, io.ram_width2, width_q);
  assign fit3    = fits(id3_q, io.ram_width3, width_q);
  assign any_fit = fit1 | fit2 | fit3;
  always_ff @(posedge enclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      width_q <= '0;
      id1_q   <= '0;
      id2_q   <= '0;
      id3_q   <= '0;
      sel_q   <= '0;
      code_q  <= '0;
      alloc_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      id1_q   <= id1_d;
      id2_q   <= id2_d;
      id3_q   <= id3_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      alloc_q <= alloc_d;
      fail_q  <= fail_d;
    end
  end
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    id1_d   = id1_q;
    id2_d   = id2_q;
    id3_d   = id3_q;
    sel_d   = sel_q;
    code_d  = code_q;
    alloc_d = alloc_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE: if (io.req_valid) begin
        width_d = io.req_width;
        id1_d   = io.req_id1;
        id2_d   = io.req_id2;
        id3_d   = io.req_id3;
        sel_d   = '0;
        code_d  = 2'd2;
        state_d = (io.req_width < MIN_W || io.req_width > MAX_W) ? RESP : RD;
      end
      RD:   state_d = WAIT;
      WAIT: state_d = EVAL;
      EVAL: begin
        sel_d   = io.strike ? '0 : fit1 ? id1_q : fit2 ? id2_q : fit3 ? id3_q : '0;
        code_d  = io.strike ? 2'd3 : any_fit ? 2'd0 : 2'd1;
        state_d = (!io.strike && any_fit) ? WR : RESP;
      end
      WR:   state_d = WRX;
      WRX:  state_d = RESP;
      RESP: if (io.resp_ready) begin
        state_d = IDLE;
        alloc_d = (code_q == 2'd0 && alloc_q != 16'hFFFF) ? alloc_q + 16'd1 : alloc_q;
        fail_d  = (code_q != 2'd0 && fail_q != 16'hFFFF) ? fail_q + 16'd1 : fail_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ram_busy           = state_q inside {RD, WAIT, EVAL, WR, WRX};
  assign wr_phase           = state_q inside {WR, WRX};
  assign io.req_ready       = state_q == IDLE;
  assign io.resp_valid      = state_q == RESP;
  assign io.resp_id         = sel_q;
  assign io.resp_code       = code_q;
  assign io.ram_id1         = ram_busy ? id1_q : '0;
  assign io.ram_id2         = ram_busy ? id2_q : '0;
  assign io.ram_id3         = ram_busy ? id3_q : '0;
  assign io.ram_we          = state_q == WR;
  assign io.ram_write_id    = wr_phase ? sel_q : '0;
  assign io.ram_write_width = wr_phase ? width_q : '0;
  assign io.ram_strike      = 1'b0;
  assign io.alloc_count     = alloc_q;
  assign io.fail_count      = fail_q;
endmodule
